// File: rtl/mult4_seq_pkg.sv
// Shared types and sizing helpers for the mult4_seq shift-and-add multiplier.
package mult4_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Step counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult4_seq_add.sv
// WIDTH-bit ripple-carry adder; the only arithmetic resource of mult4_seq.
module mult4_seq_add
  import mult4_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic [WIDTH-1:0] s,
  output logic             carryout
);

  logic [WIDTH:0] c;

  assign c[0] = carryin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carryout = c[WIDTH];

endmodule

// File: rtl/mult4_seq.sv
// Sequential shift-and-add unsigned multiplier with valid/ready ports.
// Optional MULT4_SEQ_EARLY_TERM_EN finalizes once the remaining multiplier bits are zero.
module mult4_seq
  import mult4_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_d;
  logic [WIDTH-1:0]   m, m_d;
  logic [2*WIDTH-1:0] p, p_d;
  logic [CW-1:0]      cnt, cnt_d;

  logic [WIDTH-1:0]   p_hi, p_lo, addend, sum;
  logic               carry;
  logic [2*WIDTH-1:0] step_p;
  logic               step_last;

  assign p_hi   = p[2*WIDTH-1:WIDTH];
  assign p_lo   = p[WIDTH-1:0];
  assign addend = p_lo[0] ? m : '0;

  mult4_seq_add #(.WIDTH(WIDTH)) u_add (
    .a        (p_hi),
    .b        (addend),
    .carryin  (1'b0),
    .s        (sum),
    .carryout (carry)
  );

  // Carry lands in the MSB as the accumulator and multiplier shift right together.
  assign step_p    = {carry, sum, p_lo[WIDTH-1:1]};
  assign step_last = (cnt == CW'(1));

`ifdef MULT4_SEQ_EARLY_TERM_EN
  logic [WIDTH-1:0] live_mask;
  logic             live_zero;

  assign live_mask = ~({WIDTH{1'b1}} << cnt);
  assign live_zero = ((p_lo & live_mask) == '0);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      m     <= m_d;
      p     <= p_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state;
    m_d     = m;
    p_d     = p;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (start_valid) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MULT4_SEQ_EARLY_TERM_EN
        if (live_zero) begin
          p_d     = p >> cnt;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          p_d   = step_p;
          cnt_d = cnt - CW'(1);
          if (step_last) state_d = DONE;
        end
`else
        p_d   = step_p;
        cnt_d = cnt - CW'(1);
        if (step_last) state_d = DONE;
`endif
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign result       = p;

endmodule

// File: tb/tb_mult4_seq.sv
// Scoreboard bench for mult4_seq: randomized handshakes against a plain-arithmetic product/latency model.
module tb_mult4_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_valid = 1'b0;
  logic           result_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           start_ready;
  logic           result_valid;
  logic           busy;
  logic [2*W-1:0] result;

  always #5 clk = ~clk;

  mult4_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    int             rise;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_accept = 0;
  int   rr_mode = 0;
  bit   inflight = 1'b0;
  bit   seen_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from the acceptance edge until result_valid is seen high.
  function automatic int exp_lat(input logic [W-1:0] bv);
    int need = 1;
    for (int i = 0; i < W; i++)
      if (bv[i]) need = (i + 2 > W) ? W : i + 2;
`ifndef MULT4_SEQ_EARLY_TERM_EN
    need = W;
`endif
    return need;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       result_ready = 1'b1;
      1:       result_ready = 1'($urandom_range(0, 1));
      default: result_ready = 1'b0;
    endcase
  end

  // Monitor: model acceptance, compare outputs, retire on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("start_ready", start_ready, !inflight);
      check("busy", busy, inflight);
      if (!inflight) begin
        check("valid_idle", result_valid, 1'b0);
        if (start_valid) begin
          exp_t e;
          e.prod = (2*W)'(int'(a) * int'(b));
          e.rise = cyc + 1 + exp_lat(b);
          sb.push_back(e);
          inflight   = 1'b1;
          seen_valid = 1'b0;
          n_accept++;
        end
      end else if (result_valid) begin
        if (!seen_valid) begin
          check("latency", cyc, sb[0].rise);
          seen_valid = 1'b1;
        end
        check("result", result, sb[0].prod);
        if (result_ready) begin
          void'(sb.pop_front());
          inflight = 1'b0;
        end
      end else if (cyc == sb[0].rise) begin
        check("valid_late", result_valid, 1'b1);
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    int start_n = n_accept;
    int k = 0;
    a = av;
    b = bv;
    start_valid = 1'b1;
    while (n_accept == start_n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_accept == start_n) check("accept_timeout", 1'b0, 1'b1);
    start_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (inflight && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (inflight) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, '0);
    check({tag, "_valid"}, result_valid, 1'b0);
    check({tag, "_ready"}, start_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int unsigned off;
    int unsigned mul;
    logic [7:0]  idx;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    rr_mode = 0;
    issue(4'd15, 4'd15); drain();
    issue(4'd0,  4'd9);  drain();
    issue(4'd9,  4'd0);  drain();
    issue(4'd9,  4'd2);  drain();
    issue(4'd1,  4'd1);  drain();

    // Stall in DONE with a start_valid pulse that must be ignored.
    rr_mode = 2;
    issue(4'd7, 4'd6);
    repeat (W + 1) begin @(posedge clk); #1; end
    a = 4'd3; b = 4'd3; start_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rr_mode = 0;
    drain();

    // Asynchronous reset in the middle of a run.
    issue(4'd12, 4'd11);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    sb.delete();
    inflight = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd3, 4'd5); drain();

    // All 256 pairs back-to-back in a random permutation with random stalls.
    rr_mode = 1;
    off = $urandom;
    mul = $urandom | 32'd1;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(int'(i) * mul + off);
      issue(idx[7:4], idx[3:0]);
    end
    for (int i = 0; i < 40; i++) issue(W'($urandom), W'($urandom));
    drain();
    rr_mode = 0;
    repeat (3) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult4_seq.md
# mult4_seq

Sequential shift-and-add multiplier controller: one shared WIDTH-bit adder is sequenced over WIDTH cycles instead of WIDTH-1 cascaded adder stages. It produces the full 2·WIDTH-bit unsigned product. It sits between a requesting datapath (valid/ready operand port) and a consumer (valid/ready result port) in the lab arithmetic hierarchy. It trades latency for area relative to the combinational array multiplier.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  in  1  rising-edge clock; the single clock of the block
- rst_n  in  1  reset, asynchronous assert, active-low
- start_valid  in  1  operands a/b are valid
- start_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- result_valid  out  1  product available
- result_ready  in  1  consumer takes product
- result  out  2·WIDTH  product a·b
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE. All registers are cleared on reset: result = 0, result_valid = 0, start_ready = 1, busy = 0, and the step counter = 0.
- start_ready = (state == IDLE). Acceptance = start_valid && start_ready. On the acceptance edge:
  - a is latched into the multiplicand register M.
  - P = {WIDTH'b0, b}: the hi half is the accumulator and the lo half holds the unconsumed multiplier bits.
  - cnt = WIDTH, state → RUN.
- RUN step (one per edge):
  - {c, s} = P.hi + (P.lo[0] ? M : 0), computed by the adder with carry-in 0 and carry-out c.
  - P = {c, s, P.lo} >> 1.
  - cnt decrements. When cnt reaches 0, state → DONE.
- DONE: result = P and result_valid = 1. State → IDLE on the edge where result_ready = 1.
- result is held stable while result_valid = 1 and result_ready = 0.
- start_valid during RUN or DONE is not accepted. The a and b inputs are sampled only on the acceptance edge.
- Width rule: the accumulator sum is WIDTH+1 bits, and the carry enters the MSB of P on the shift. No overflow is possible, since the product of two WIDTH-bit values is at most 2·WIDTH bits.
- Reset mid-RUN or mid-DONE: the block returns immediately to IDLE with all outputs at their reset values. The in-flight product is discarded.

## Timing
- Acceptance edge t. RUN steps occur on edges t+1 … t+WIDTH. result_valid is high after edge t+WIDTH. Latency is WIDTH cycles (4 for the default).
- result_valid and result_ready both high at edge u → IDLE after u, so start_ready is high from u. Minimum issue interval is WIDTH+2 cycles.
- There is no combinational path from any input to any output except through registered state. start_ready depends only on state.

## Configuration
- MULT4_SEQ_EARLY_TERM_EN defined:
  - At each RUN edge, if the unconsumed multiplier bits in P.lo (the top cnt bits, aligned at bit 0) are all zero, the block finalizes: P = {P.hi, P.lo} >> cnt, cnt = 0, state → DONE.
  - b = 0 → DONE after edge t+1.
  - The product value is unchanged; only latency shortens.
- Not defined: exactly WIDTH RUN cycles for every operand pair.

## Structure
- Package mult4_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter width = $clog2(WIDTH+1)
- One sub-module, mult4_seq_add: WIDTH-bit ripple adder with carryin, S, and carryout. It is instantiated once and is the only arithmetic resource.
- The FSM, P/M registers, and counter live in the top module.

## Test plan
- 15×15, result_ready = 1 → result = 225 (8'hE1); result_valid rises after edge t+4; start_ready low from t+1 until the handshake.
- 0×9 and 9×0 → result = 0. Without the macro, latency is 4. With MULT4_SEQ_EARLY_TERM_EN, 9×0 completes after t+1.
- 9×2 → 18. Latency is 3 with the macro and 4 without. 1×1 → 1 with latency 2 (macro) or 4 (no macro).
- 7×6 with result_ready held low for 5 cycles → result stays 42 and result_valid stays 1. A start_valid pulse during the wait is not accepted.
- rst_n asserted on edge t+2 of 12×11 → all outputs return to reset values asynchronously. A following 3×5 yields 15 with normal latency.
- Exhaustive: all 256 a×b pairs back-to-back with random result_ready stalls → each result equals a·b. Run with and without the macro.
